// File: rtl/johnson_pkg.sv
// Shared types and width-generic Johnson-code helpers for the decoder.
// Helpers take the live width w as an argument and operate on a MaxW-bit container.
package johnson_pkg;

  typedef enum logic [1:0] {StSearch, StAcq, StLocked} jd_state_e;

  localparam int unsigned MaxW = 32;

  function automatic logic [MaxW-1:0] johnson_succ(input logic [MaxW-1:0] c,
                                                   input int unsigned w);
    logic [MaxW-1:0] r;
    r = '0;
    for (int unsigned i = 1; i < MaxW; i++) begin
      if (i < w) r[i] = c[i-1];
    end
    r[0] = ~c[w-1];
    return r;
  endfunction

  function automatic logic [MaxW-1:0] johnson_pred(input logic [MaxW-1:0] c,
                                                   input int unsigned w);
    logic [MaxW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MaxW - 1; i++) begin
      if (i + 1 < w) r[i] = c[i+1];
    end
    r[w-1] = ~c[0];
    return r;
  endfunction

  // Legal codes have at most one 0/1 boundary between adjacent bits.
  function automatic logic johnson_legal(input logic [MaxW-1:0] c, input int unsigned w);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < MaxW - 1; i++) begin
      if (i + 1 < w && c[i] != c[i+1]) n++;
    end
    return n <= 1;
  endfunction

  function automatic int unsigned johnson_idx(input logic [MaxW-1:0] c, input int unsigned w);
    int unsigned pop;
    pop = 0;
    for (int unsigned i = 0; i < MaxW; i++) begin
      if (i < w && c[i]) pop++;
    end
    return c[w-1] ? (2 * w - pop) : pop;
  endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson code classifier: legality, state index and one-hot index.
module johnson_code_decode
  import johnson_pkg::*;
#(
  parameter int unsigned W = 4,
  localparam int unsigned IdxW = $clog2(2 * W)
) (
  input  logic [W-1:0]    q_i,
  output logic            legal_o,
  output logic [IdxW-1:0] idx_o,
  output logic [2*W-1:0]  onehot_o
);

  always_comb begin
    legal_o  = johnson_legal(MaxW'(q_i), W);
    idx_o    = IdxW'(johnson_idx(MaxW'(q_i), W));
    onehot_o = '0;
    onehot_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson sequence monitor: decodes samples, tracks successor lock, counts errors.
// Define JOHNSON_DECODER_DIR_EN to also accept reverse steps and expose dir_o.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int unsigned W        = 4,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned ERR_W    = 8,
  localparam int unsigned IdxW    = $clog2(2 * W)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic [W-1:0]    q_i,
  output logic [IdxW-1:0] idx_o,
  output logic [2*W-1:0]  onehot_o,
  output logic            legal_o,
  output logic            locked_o,
  output logic            err_pulse_o,
  output logic [ERR_W-1:0] err_cnt_o
`ifdef JOHNSON_DECODER_DIR_EN
  ,
  output logic            dir_o
`endif
);

  localparam int unsigned RunW = $clog2(LOCK_CNT + 1);

  jd_state_e        state_q, state_d;
  logic [W-1:0]     prev_q, prev_d;
  logic [RunW-1:0]  run_q, run_d, run_inc;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [2*W-1:0]   onehot_q, onehot_d;
  logic             legal_q, legal_d;
  logic             err_pulse_q, err;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic             dec_legal;
  logic [IdxW-1:0]  dec_idx;
  logic [2*W-1:0]   dec_onehot;
  logic             fwd, bwd, step_ok;

  johnson_code_decode #(
    .W(W)
  ) u_decode (
    .q_i     (q_i),
    .legal_o (dec_legal),
    .idx_o   (dec_idx),
    .onehot_o(dec_onehot)
  );

  assign fwd     = (q_i == W'(johnson_succ(MaxW'(prev_q), W)));
  assign step_ok = fwd | bwd;
  assign run_inc = run_q + RunW'(1);

`ifdef JOHNSON_DECODER_DIR_EN
  logic dir_q, dir_d;

  assign bwd = (q_i == W'(johnson_pred(MaxW'(prev_q), W)));

  always_comb begin
    dir_d = dir_q;
    if (en_i && state_q != StSearch && step_ok) dir_d = fwd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir_q <= 1'b0;
    else        dir_q <= dir_d;
  end

  assign dir_o = dir_q;
`else
  assign bwd = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    run_d    = run_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    legal_d  = legal_q;
    err      = 1'b0;
    if (en_i) begin
      legal_d = dec_legal;
      // Any legal sample becomes history, even one that breaks lock.
      if (dec_legal) begin
        idx_d    = dec_idx;
        onehot_d = dec_onehot;
        prev_d   = q_i;
      end
      unique case (state_q)
        StSearch: begin
          if (dec_legal) begin
            state_d = StAcq;
            run_d   = '0;
          end else begin
            err = 1'b1;
          end
        end
        StAcq: begin
          if (!dec_legal) begin
            err     = 1'b1;
            state_d = StSearch;
          end else if (step_ok) begin
            run_d = run_inc;
            if (32'(run_inc) >= LOCK_CNT) state_d = StLocked;
          end else begin
            run_d = '0;
          end
        end
        StLocked: begin
          if (!step_ok) begin
            err     = 1'b1;
            state_d = StSearch;
          end
        end
        default: state_d = StSearch;
      endcase
    end
    err_cnt_d = (err && err_cnt_q != '1) ? err_cnt_q + ERR_W'(1) : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StSearch;
      prev_q      <= '0;
      run_q       <= '0;
      idx_q       <= '0;
      onehot_q    <= '0;
      legal_q     <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      run_q       <= run_d;
      idx_q       <= idx_d;
      onehot_q    <= onehot_d;
      legal_q     <= legal_d;
      err_pulse_q <= err;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign idx_o       = idx_q;
  assign onehot_o    = onehot_q;
  assign legal_o     = legal_q;
  assign locked_o    = (state_q == StLocked);
  assign err_pulse_o = err_pulse_q;
  assign err_cnt_o   = err_cnt_q;

endmodule
